mips_mem_arbiter: RTL and testbench

- Arbitrates the single-ported unified instruction/data memory of the mips_32 core between two requesters: the instruction-fetch stage (IF) and the data-memory stage (DM, i.e. LW/SW).
- Fixed priority favours DM. A starvation counter guarantees IF forward progress.
- Sequences each access over a fixed memory latency and returns read data or a write acknowledgement to the owner.
- Sits between the pipeline stage logic and the memory array.

---
 rtl/mips_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbiter for the mips_32 unified instruction/data memory: DM-priority with IF anti-starvation.
// Define MIPS_ARB_STATS_EN to add grant and contention statistics counters.
module mips_mem_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          halted,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef MIPS_ARB_STATS_EN
   ,
   output logic [15:0]   if_grant_cnt,
   output logic [15:0]   dm_grant_cnt,
   output logic [15:0]   contend_cnt
`endif
);

   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] StarveLim = SW'(STARVE_MAX);
   localparam logic [3:0]    LatLim    = 4'(MEM_LAT);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          state_q, state_d;
   logic            owner_q, owner_d;  // 1 = DM, 0 = IF
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [3:0]      lat_q, lat_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
   logic            ifr, dmr, contend, pick_if, first;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      lat_d      = lat_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      ifr        = if_req & ~halted;
      dmr        = dm_req;
      contend    = ifr & dmr;
      pick_if    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ifr || dmr) begin
               pick_if = ifr & (~dmr | ((STARVE_MAX != 0) && (starve_q == StarveLim)));
               owner_d = ~pick_if;
               we_d    = pick_if ? 1'b0 : dm_we;
               addr_d  = pick_if ? if_addr : dm_addr;
               wdata_d = pick_if ? '0 : dm_wdata;
               lat_d   = '0;
               state_d = StAccess;
               if (pick_if) begin
                  starve_d = '0;
               end else if (contend && (STARVE_MAX != 0) && (starve_q != StarveLim)) begin
                  starve_d = starve_q + 1'b1;
               end
            end
         end
         StAccess: begin
            // lat_q == MEM_LAT marks the cycle in which mem_rdata is valid
            if (lat_q == LatLim) begin
               lat_d   = '0;
               state_d = StResp;
               if (!we_q) begin
                  if (owner_q) dm_rdata_d = mem_rdata;
                  else         if_rdata_d = mem_rdata;
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_q      <= '0;
         starve_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         lat_q      <= lat_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign first     = (state_q == StAccess) && (lat_q == '0);
   assign if_gnt    = first & ~owner_q;
   assign dm_gnt    = first & owner_q;
   assign mem_en    = first;
   assign mem_we    = first & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rvalid = (state_q == StResp) & ~owner_q;
   assign dm_rvalid = (state_q == StResp) & owner_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign busy      = (state_q != StIdle);

`ifdef MIPS_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         if_grant_cnt <= '0;
         dm_grant_cnt <= '0;
         contend_cnt  <= '0;
      end else begin
         if (if_gnt && (if_grant_cnt != 16'hffff)) if_grant_cnt <= if_grant_cnt + 16'd1;
         if (dm_gnt && (dm_grant_cnt != 16'hffff)) dm_grant_cnt <= dm_grant_cnt + 16'd1;
         if ((state_q == StIdle) && contend && (contend_cnt != 16'hffff)) begin
            contend_cnt <= contend_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter (MEM_LAT = 1, STARVE_MAX = 2).
module tb_mips_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset, halted;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MIPS_ARB_STATS_EN
   logic [15:0] if_grant_cnt, dm_grant_cnt, contend_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mips_mem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(2)
   ) u_dut (
      .clock(clock), .reset(reset), .halted(halted),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MIPS_ARB_STATS_EN
      ,
      .if_grant_cnt(if_grant_cnt), .dm_grant_cnt(dm_grant_cnt), .contend_cnt(contend_cnt)
`endif
   );

   always #5 clock = ~clock;

   // Read-only memory image; data valid the cycle after mem_en (MEM_LAT = 1).
   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'd0:   rom = 32'h280a00c8;
         32'd1:   rom = 32'h00001234;
         32'd200: rom = 32'd7;
         default: rom = 32'hdead0000 | a;
      endcase
   endfunction

   always @(posedge clock) begin
      if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic idle_inputs();
      halted = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
   endtask

   int gnt_seen, busy_seen, rv_seen;

   initial begin
      mem_rdata = '0;
      idle_inputs();

      // Reset with both requests high
      if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'd200;
      do_reset();
      check("rst_outs", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy}, 32'd0);
      check("rst_data", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'd0);
      tick();
      check("rst_first_dm_gnt", {if_gnt, dm_gnt}, 32'b01);
      idle_inputs();

      // Lone fetch
      do_reset();
      if_req = 1'b1; if_addr = 32'd0;
      tick();
      check("fetch_c1_gnt", {if_gnt, dm_gnt, mem_en, mem_we, busy}, 32'b10101);
      check("fetch_c1_addr", mem_addr, 32'd0);
      if_req = 1'b0;
      tick();
      check("fetch_c2", {if_gnt, mem_en, if_rvalid, busy}, 32'b0001);
      tick();
      check("fetch_c3_rvalid", {if_rvalid, dm_rvalid, busy}, 32'b101);
      check("fetch_c3_rdata", if_rdata, 32'h280a00c8);
      tick();
      check("fetch_c4_idle", {if_rvalid, busy}, 32'b00);

      // Contention: DM load first, IF in the next IDLE
      do_reset();
      if_req = 1'b1; if_addr = 32'd1; dm_req = 1'b1; dm_addr = 32'd200;
      tick();
      check("cont_c1_gnt", {if_gnt, dm_gnt}, 32'b01);
      check("cont_c1_addr", mem_addr, 32'd200);
      dm_req = 1'b0;
      tick();
      tick();
      check("cont_c3_rvalid", {if_rvalid, dm_rvalid}, 32'b01);
      check("cont_c3_rdata", dm_rdata, 32'd7);
      tick();
      check("cont_c4_idle", {if_gnt, busy}, 32'b00);
      tick();
      check("cont_c5_if_gnt", {if_gnt, dm_gnt}, 32'b10);
      check("cont_c5_addr", mem_addr, 32'd1);
      if_req = 1'b0;
      tick();
      tick();
      check("cont_c7_if_rdata", {31'd0, if_rvalid}, 32'd1);
      check("cont_c7_if_data", if_rdata, 32'h00001234);

      // Starvation with STARVE_MAX = 2: DM, DM, IF, DM, DM, IF
      do_reset();
      if_req = 1'b1; if_addr = 32'd1; dm_req = 1'b1; dm_addr = 32'd200;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("starve_gnt%0d", k), {if_gnt, dm_gnt},
               (k == 2 || k == 5) ? 32'b10 : 32'b01);
         if (k == 5) begin
            if_req = 1'b0; dm_req = 1'b0;
         end
         tick(); tick(); tick();
      end
`ifdef MIPS_ARB_STATS_EN
      check("stats_contend", {16'd0, contend_cnt}, 32'd6);
      check("stats_if_gnt", {16'd0, if_grant_cnt}, 32'd2);
      check("stats_dm_gnt", {16'd0, dm_grant_cnt}, 32'd4);
`endif

      // Store after a load leaves dm_rdata holding the load value
      do_reset();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd200;
      tick();
      dm_req = 1'b0;
      tick(); tick(); tick();
      check("st_pre_load", dm_rdata, 32'd7);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd198; dm_wdata = 32'd5040;
      tick();
      check("st_c1_ctrl", {dm_gnt, mem_en, mem_we}, 32'b111);
      check("st_c1_addr", mem_addr, 32'd198);
      check("st_c1_wdata", mem_wdata, 32'd5040);
      dm_req = 1'b0; dm_we = 1'b0;
      tick();
      check("st_c2_ctrl", {mem_en, mem_we, dm_rvalid}, 32'b000);
      tick();
      check("st_c3_rvalid", {31'd0, dm_rvalid}, 32'd1);
      check("st_c3_rdata", dm_rdata, 32'd7);

      // Halted masks IF
      halted = 1'b1; if_req = 1'b1; if_addr = 32'd0;
      gnt_seen = 0; busy_seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k > 0) begin
            gnt_seen  += int'(if_gnt);
            busy_seen += int'(busy);
         end
      end
      check("halt_no_gnt", gnt_seen, 32'd0);
      check("halt_no_busy", busy_seen, 32'd0);
      halted = 1'b0;
      tick();
      check("unhalt_gnt", {31'd0, if_gnt}, 32'd1);
      if_req = 1'b0;
      tick(); tick(); tick();

      // Reset during an in-flight load
      do_reset();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd200;
      tick();
      check("rmid_gnt", {31'd0, dm_gnt}, 32'd1);
      dm_req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rmid_idle", {31'd0, busy}, 32'd0);
      rv_seen = 0; busy_seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         rv_seen   += int'(dm_rvalid);
         busy_seen += int'(busy);
      end
      check("rmid_no_rvalid", rv_seen, 32'd0);
      check("rmid_no_busy", busy_seen, 32'd0);
      check("rmid_rdata", dm_rdata, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
